// File: rtl/pe_recip_pkg.sv
// rtl/pe_recip_pkg.sv - shared constants and types for the PE reciprocal table and its index search
package pe_recip_pkg;

  localparam int IDX_W  = 8;
  localparam int VAL_W  = 16;
  localparam int IDX_LO = 3;
  localparam int IDX_HI = 255;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    CHECK  = 2'd2,
    DONE   = 2'd3
  } search_state_e;

  typedef struct packed {
    logic [IDX_W-1:0] index;
    logic             exact;
    logic             miss;
  } recip_result_t;

endpackage

// File: rtl/recip_index_search.sv
// rtl/recip_index_search.sv - finds the smallest table index whose reciprocal entry is <= key
// Binary search over the strictly decreasing region of the PE reciprocal table, one probe per cycle.
module recip_index_search #(
  parameter int IDX_W  = pe_recip_pkg::IDX_W,
  parameter int VAL_W  = pe_recip_pkg::VAL_W,
  parameter int IDX_LO = pe_recip_pkg::IDX_LO,
  parameter int IDX_HI = pe_recip_pkg::IDX_HI
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [VAL_W-1:0] in_key,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_index,
  output logic             out_exact,
  output logic             out_miss,
  output logic             tab_enable,
  output logic [IDX_W-1:0] tab_index,
  input  logic [VAL_W-1:0] tab_value
);

  import pe_recip_pkg::*;

  search_state_e    state;
  logic [VAL_W-1:0] key;
  logic [IDX_W-1:0] lo;
  logic [IDX_W-1:0] hi;
  logic [IDX_W:0]   mid_sum;
  logic [IDX_W-1:0] mid;
  recip_result_t    res;

  // Midpoint taken from a one-bit-wider sum so lo+hi never wraps.
  assign mid_sum = {1'b0, lo} + {1'b0, hi};
  assign mid     = mid_sum[IDX_W:1];

  assign out_index = res.index;
  assign out_exact = res.exact;
  assign out_miss  = res.miss;

  always_comb begin
    tab_enable = 1'b0;
    tab_index  = '0;
    case (state)
      SEARCH: begin
        if (lo != hi) begin
          tab_enable = 1'b1;
          tab_index  = mid;
        end
      end
      CHECK: begin
        tab_enable = 1'b1;
        tab_index  = lo;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key       <= '0;
      lo        <= '0;
      hi        <= '0;
      res       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            key      <= in_key;
            lo       <= IDX_W'(IDX_LO);
            hi       <= IDX_W'(IDX_HI);
            in_ready <= 1'b0;
            state    <= SEARCH;
          end
        end
        SEARCH: begin
          if (lo == hi) begin
            state <= CHECK;
          end else if (tab_value <= key) begin
            hi <= mid;
          end else begin
            lo <= mid + IDX_W'(1);
          end
        end
        CHECK: begin
          // The final probe tells apart an exact hit, a plain hit and a key below the whole range.
          res.index <= lo;
          res.exact <= (tab_value == key);
          res.miss  <= (tab_value > key);
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_recip_index_search.sv
// tb/tb_recip_index_search.sv - directed and randomised checks of recip_index_search against a table model
module tb_recip_index_search;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_key;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_index;
  logic        out_exact;
  logic        out_miss;
  logic        tab_enable;
  logic [7:0]  tab_index;
  logic [15:0] tab_value;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  recip_index_search dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_index  (out_index),
    .out_exact  (out_exact),
    .out_miss   (out_miss),
    .tab_enable (tab_enable),
    .tab_index  (tab_index),
    .tab_value  (tab_value)
  );

  // Shared PE reciprocal table: floor(79581 / i), saturated to 16 bits.
  function automatic logic [15:0] recip_val(input logic [7:0] i);
    int unsigned v;
    if (i == 8'd0) return 16'hffff;
    v = 79581 / int'(i);
    if (v > 65535) return 16'hffff;
    return v[15:0];
  endfunction

  always_comb tab_value = tab_enable ? recip_val(tab_index) : 16'h0000;

  // Linear-scan reference: {index, exact, miss}.
  function automatic logic [9:0] ref_search(input logic [15:0] k);
    for (int i = 3; i <= 255; i++) begin
      if (recip_val(8'(i)) <= k) return {8'(i), recip_val(8'(i)) == k, 1'b0};
    end
    return {8'd255, 1'b0, 1'b1};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic issue(input logic [15:0] k, output int lat);
    wait_ready();
    in_key   = k;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [15:0] k, input logic [7:0] e_idx,
                          input logic e_exact, input logic e_miss);
    int lat;
    issue(k, lat);
    check({tag, "_latency"}, 32'(lat <= 10), 1);
    check(tag, {out_valid, out_index, out_exact, out_miss}, {1'b1, e_idx, e_exact, e_miss});
    retire();
  endtask

  initial begin
    int lat;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_key    = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", {in_ready, out_valid, out_index, out_exact, out_miss, tab_enable, tab_index},
          {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    directed("exact_8",    16'h26db, 8'd8,   1'b1, 1'b0);
    directed("above_8",    16'h26dc, 8'd8,   1'b0, 1'b0);
    directed("below_8",    16'h26da, 8'd9,   1'b0, 1'b0);
    directed("exact_255",  16'h0138, 8'd255, 1'b1, 1'b0);
    directed("miss",       16'h0100, 8'd255, 1'b0, 1'b1);
    directed("top_key",    16'hffff, 8'd3,   1'b0, 1'b0);

    // Backpressure: result must hold while out_ready stays low.
    issue(16'h26db, lat);
    check("bp_latency", 32'(lat <= 10), 1);
    for (int c = 0; c < 20; c++) begin
      check("bp_hold", {out_valid, in_ready, tab_enable, out_index, out_exact, out_miss},
            {1'b1, 1'b0, 1'b0, 8'd8, 1'b1, 1'b0});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release", {in_ready, out_valid}, {1'b1, 1'b0});

    // Asynchronous reset in the middle of a search.
    wait_ready();
    in_key   = 16'h26db;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("mid_search_busy", {in_ready, tab_enable}, {1'b0, 1'b1});
    rst_n = 1'b0;
    #1;
    check("mid_search_reset", {in_ready, out_valid, out_index, out_exact, out_miss, tab_enable, tab_index},
          {1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 8'd0});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    directed("after_reset", 16'h4db7, 8'd4, 1'b1, 1'b0);

    // Random keys, random backpressure, stray in_valid pulses while busy.
    for (int t = 0; t < 24; t++) begin
      logic [15:0] k;
      logic [9:0]  exp_r;
      bit          seen;
      bit          retired;
      bit          hs;
      int          cyc;
      case (t)
        0:       k = 16'h679f;
        1:       k = 16'h0139;
        2:       k = 16'h0137;
        3:       k = 16'h0000;
        default: k = 16'($urandom);
      endcase
      exp_r = ref_search(k);
      wait_ready();
      in_key   = k;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      seen    = 1'b0;
      retired = 1'b0;
      cyc     = 0;
      while (!retired && cyc < 60) begin
        if (out_valid) begin
          if (!seen) begin
            check("rand_result", {out_index, out_exact, out_miss}, 32'(exp_r));
            check("rand_latency", 32'(cyc <= 10), 1);
            seen = 1'b1;
          end
          in_valid  = 1'b0;
          out_ready = 1'($urandom_range(0, 1));
        end else begin
          in_valid  = 1'($urandom_range(0, 1));
          in_key    = 16'($urandom);
          out_ready = 1'($urandom_range(0, 1));
        end
        check("rand_busy", 32'(in_ready), 0);
        hs = out_valid && out_ready;
        @(posedge clk); #1;
        cyc++;
        if (hs) retired = 1'b1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b0;
      if (!retired) check("rand_timeout", 0, 1);
      check("rand_idle", {in_ready, out_valid}, {1'b1, 1'b0});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
